ddr3_req_sched: RTL
===================

# ddr3_req_sched

Request scheduler between the AXI front-end and the DDR3 memory-controller FSM. It accepts independent WRITE and READ request streams, each using a req/ack handshake, and arbitrates them onto a single request port. Arbitration is read-priority with a bounded consecutive-grant limit, so neither side starves. An optional same-address hazard check forces a pending WRITE ahead of a READ to the same burst.

## Interface
- ADDRS, 25: request address width (row + column bits).
- REQID, 4: transaction-ID width.
- BURST_LSB, 2: address LSBs ignored for hazard compare; burst alignment is 2^BURST_LSB words.
- MAX_RUN, 4: maximum consecutive grants to one side while the other side is pending; legal range 1..15.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_hold_i  in  1  while high, no new grant is issued (refresh/config window).
- wr_req_i  in  1  WRITE request; held with tid/adr stable until wr_ack_o.
- wr_ack_o  out  1  one-cycle WRITE acknowledge.
- wr_err_o  out  1  error flag, valid with wr_ack_o.
- wr_tid_i  in  REQID  WRITE ID.
- wr_adr_i  in  ADDRS  WRITE address.
- rd_req_i  in  1  READ request; same handshake rules as wr_req_i.
- rd_ack_o  out  1  one-cycle READ acknowledge.
- rd_err_o  out  1  error flag, valid with rd_ack_o.
- rd_tid_i  in  REQID  READ ID.
- rd_adr_i  in  ADDRS  READ address.
- mem_req_o  out  1  request to the FSM.
- mem_wr_o  out  1  1 = WRITE, 0 = READ; valid while mem_req_o is high.
- mem_ack_i  in  1  FSM acknowledge.
- mem_err_i  in  1  FSM error flag, valid with mem_ack_i.
- mem_tid_o  out  REQID  granted ID (registered).
- mem_adr_o  out  ADDRS  granted address (registered).

## Operation
- FSM states: IDLE, BUSY_WR, BUSY_RD.
- IDLE:
  - If mem_hold_i is high, or neither request is pending, stay in IDLE.
  - Otherwise choose a winner, latch its tid/adr into mem_tid_o/mem_adr_o, set mem_wr_o, and go to BUSY_WR or BUSY_RD.
- Winner selection, in priority order:
  1. Hazard: if enabled, both sides pending, and rd_adr_i[ADDRS-1:BURST_LSB] == wr_adr_i[ADDRS-1:BURST_LSB], WRITE wins.
  2. Run limit: if both sides pending and run_cnt == MAX_RUN for the last-granted side, the other side wins.
  3. Default: READ wins.
  4. A lone pending request always wins.
- run_cnt (4-bit):
  - Increments when the granted side equals the last-granted side; otherwise it is set to 1.
  - It is cleared to 0 on any grant made while the other side is not pending.
  - It saturates at MAX_RUN.
- BUSY_x:
  - mem_req_o is held high.
  - On mem_ack_i, assert x_ack_o = 1 and x_err_o = mem_err_i combinationally in the same cycle, then return to IDLE.
  - mem_hold_i does not affect an outstanding request.
- Simultaneous events: a requester may drop and re-raise its request on the cycle after its ack; IDLE samples the new value. No request is ever acked twice.
- A requester dropping its req_i while in BUSY is a protocol violation. The request is still completed.
- reset_n low, asynchronously:
  - State returns to IDLE and run_cnt to 0.
  - Last-granted side resets to WRITE, so the first contended grant goes to READ.
  - An outstanding request is abandoned, with no ack.

## Timing
- Reset values: mem_req_o = 0, mem_wr_o = 0, mem_tid_o = 0, mem_adr_o = 0, wr_ack_o = 0, rd_ack_o = 0, wr_err_o = 0, rd_err_o = 0.
- Grant latency: a request sampled in IDLE at edge N gives mem_req_o high from cycle N+1.
- Ack path is zero-latency, mem_ack_i to x_ack_o.
- Peak throughput is one request per 2 cycles (IDLE + BUSY with immediate ack).
- mem_req_o, mem_wr_o, mem_tid_o and mem_adr_o are registered and stable throughout BUSY.

## Configuration
- Macro DDR3_SCHED_HAZARD_EN:
  - Defined: the same-burst read-after-write compare is built and rule 1 applies.
  - Undefined: the compare logic is omitted and arbitration uses only rules 2 to 4. The READ side may then overtake a same-address WRITE; upstream must order those itself.

## Structure
- Shared package ddr3_pkg holds:
  - the FSM state encoding, sched_state_t {IDLE, BUSY_WR, BUSY_RD};
  - the MAX_RUN legal bound;
  - the req/ack side enum {SIDE_WR, SIDE_RD}.
- One sub-module is natural: ddr3_sched_pick, the combinational winner selection (hazard compare, run limit, priority) feeding the registered FSM.

## Test plan
- Lone READ: rd_req_i = 1, rd_adr_i = 0x0000100, rd_tid_i = 3, mem_ack_i on the 2nd BUSY cycle.
  - Expect mem_req_o high from the cycle after the sample, mem_wr_o = 0, mem_adr_o = 0x0000100, mem_tid_o = 3.
  - Expect one rd_ack_o pulse, coincident with mem_ack_i.
- Contention, MAX_RUN = 4: WRITE and READ continuously pending, immediate acks, hazard off.
  - Expect a grant sequence of 4 READ, 1 WRITE, 4 READ, 1 WRITE, and so on.
- Hazard (macro defined): both pending with wr_adr_i = 0x0000104 and rd_adr_i = 0x0000107 (same burst, BURST_LSB = 2).
  - Expect WRITE granted first, then READ.
  - Repeat with rd_adr_i = 0x0000108: expect READ first.
- Hold: mem_hold_i = 1 with both requests pending for 10 cycles.
  - Expect mem_req_o = 0 throughout; grant issued the cycle after mem_hold_i falls.
  - mem_hold_i asserted during BUSY_WR: the request still completes with wr_ack_o.
- Error forwarding: mem_err_i = 1 with mem_ack_i in BUSY_RD.
  - Expect rd_ack_o = 1 and rd_err_o = 1; wr_ack_o and wr_err_o stay 0.
- Reset mid-BUSY_WR: pulse reset_n low asynchronously between edges.
  - Expect mem_req_o = 0 immediately and no ack.
  - After release with both pending, expect the first grant to be READ.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared types for the DDR3 request scheduler: FSM state, requester side and run-limit bound.
package ddr3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_WR,
        BUSY_RD
    } sched_state_t;

    typedef enum logic {
        SIDE_WR,
        SIDE_RD
    } sched_side_t;

    localparam int unsigned RUN_MAX = 15;

    function automatic sched_side_t other_side(input sched_side_t s);
        return (s == SIDE_WR) ? SIDE_RD : SIDE_WR;
    endfunction

endpackage

// File: rtl/ddr3_sched_pick.sv
// Combinational winner selection: hazard compare, run limit, read priority.
// Same-burst read-after-write ordering is built only with DDR3_SCHED_HAZARD_EN defined.
module ddr3_sched_pick
    import ddr3_pkg::*;
#(
    parameter int unsigned ADDRS     = 25,
    parameter int unsigned BURST_LSB = 2,
    parameter int unsigned MAX_RUN   = 4
) (
    input  logic              wr_req_i,
    input  logic              rd_req_i,
    input  logic [ADDRS-1:0]  wr_adr_i,
    input  logic [ADDRS-1:0]  rd_adr_i,
    input  sched_side_t       last_side_i,
    input  logic [3:0]        run_cnt_i,
    output logic              valid_o,
    output sched_side_t       side_o
);

    localparam logic [3:0] RUN_LIM = 4'(MAX_RUN);

    logic same_burst;
    logic contended;

`ifdef DDR3_SCHED_HAZARD_EN
    logic unused_burst_bits;
    assign same_burst        = (wr_adr_i[ADDRS-1:BURST_LSB] == rd_adr_i[ADDRS-1:BURST_LSB]);
    assign unused_burst_bits = ^{wr_adr_i[BURST_LSB-1:0], rd_adr_i[BURST_LSB-1:0]};
`else
    logic unused_adr;
    assign same_burst = 1'b0;
    assign unused_adr = ^{wr_adr_i, rd_adr_i};
`endif

    assign contended = wr_req_i && rd_req_i;

    always_comb begin
        valid_o = wr_req_i || rd_req_i;
        side_o  = SIDE_RD;
        if (!rd_req_i) begin
            side_o = SIDE_WR;
        end else if (contended) begin
            if (same_burst) begin
                side_o = SIDE_WR;
            end else if (run_cnt_i == RUN_LIM) begin
                side_o = other_side(last_side_i);
            end
        end
    end

endmodule

// File: rtl/ddr3_req_sched.sv
// Arbitrates WRITE/READ req/ack streams onto one DDR3 controller request port.
// Optional macro DDR3_SCHED_HAZARD_EN enables same-burst write-before-read ordering.
module ddr3_req_sched
    import ddr3_pkg::*;
#(
    parameter int unsigned ADDRS     = 25,
    parameter int unsigned REQID     = 4,
    parameter int unsigned BURST_LSB = 2,
    parameter int unsigned MAX_RUN   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              mem_hold_i,
    input  logic              wr_req_i,
    output logic              wr_ack_o,
    output logic              wr_err_o,
    input  logic [REQID-1:0]  wr_tid_i,
    input  logic [ADDRS-1:0]  wr_adr_i,
    input  logic              rd_req_i,
    output logic              rd_ack_o,
    output logic              rd_err_o,
    input  logic [REQID-1:0]  rd_tid_i,
    input  logic [ADDRS-1:0]  rd_adr_i,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    input  logic              mem_ack_i,
    input  logic              mem_err_i,
    output logic [REQID-1:0]  mem_tid_o,
    output logic [ADDRS-1:0]  mem_adr_o
);

    localparam int unsigned RUN_LIM_I = (MAX_RUN < 1) ? 1 : ((MAX_RUN > RUN_MAX) ? RUN_MAX : MAX_RUN);
    localparam logic [3:0]  RUN_LIM   = 4'(RUN_LIM_I);

    sched_state_t     state_q, state_d;
    sched_side_t      last_side_q, last_side_d;
    logic [3:0]       run_cnt_q, run_cnt_d;
    logic             mem_wr_q, mem_wr_d;
    logic [REQID-1:0] mem_tid_q, mem_tid_d;
    logic [ADDRS-1:0] mem_adr_q, mem_adr_d;

    logic             pick_valid;
    sched_side_t      pick_side;

    ddr3_sched_pick #(
        .ADDRS     (ADDRS),
        .BURST_LSB (BURST_LSB),
        .MAX_RUN   (RUN_LIM_I)
    ) u_pick (
        .wr_req_i    (wr_req_i),
        .rd_req_i    (rd_req_i),
        .wr_adr_i    (wr_adr_i),
        .rd_adr_i    (rd_adr_i),
        .last_side_i (last_side_q),
        .run_cnt_i   (run_cnt_q),
        .valid_o     (pick_valid),
        .side_o      (pick_side)
    );

    always_comb begin
        state_d     = state_q;
        last_side_d = last_side_q;
        run_cnt_d   = run_cnt_q;
        mem_wr_d    = mem_wr_q;
        mem_tid_d   = mem_tid_q;
        mem_adr_d   = mem_adr_q;
        wr_ack_o    = 1'b0;
        wr_err_o    = 1'b0;
        rd_ack_o    = 1'b0;
        rd_err_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mem_hold_i && pick_valid) begin
                    last_side_d = pick_side;
                    if (pick_side == SIDE_WR) begin
                        state_d   = BUSY_WR;
                        mem_wr_d  = 1'b1;
                        mem_tid_d = wr_tid_i;
                        mem_adr_d = wr_adr_i;
                    end else begin
                        state_d   = BUSY_RD;
                        mem_wr_d  = 1'b0;
                        mem_tid_d = rd_tid_i;
                        mem_adr_d = rd_adr_i;
                    end
                    // Uncontended grants reset the run so a lone stream never trips the limit.
                    if (!(wr_req_i && rd_req_i)) begin
                        run_cnt_d = '0;
                    end else if (pick_side == last_side_q) begin
                        run_cnt_d = (run_cnt_q >= RUN_LIM) ? RUN_LIM : run_cnt_q + 4'd1;
                    end else begin
                        run_cnt_d = 4'd1;
                    end
                end
            end
            BUSY_WR: begin
                if (mem_ack_i) begin
                    wr_ack_o = 1'b1;
                    wr_err_o = mem_err_i;
                    state_d  = IDLE;
                end
            end
            BUSY_RD: begin
                if (mem_ack_i) begin
                    rd_ack_o = 1'b1;
                    rd_err_o = mem_err_i;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_side_q <= SIDE_WR;
            run_cnt_q   <= '0;
            mem_wr_q    <= 1'b0;
            mem_tid_q   <= '0;
            mem_adr_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_side_q <= last_side_d;
            run_cnt_q   <= run_cnt_d;
            mem_wr_q    <= mem_wr_d;
            mem_tid_q   <= mem_tid_d;
            mem_adr_q   <= mem_adr_d;
        end
    end

    assign mem_req_o = (state_q != IDLE);
    assign mem_wr_o  = mem_wr_q;
    assign mem_tid_o = mem_tid_q;
    assign mem_adr_o = mem_adr_q;

endmodule
